// File: rtl/uart_rx_csr.sv
// UART_RX CSR hardware side: 8N1 deserialiser, RxFIFO and read-to-clear head register.
// Optional sticky framing-error flag at csr_rdata[29] when UART_RX_FERR_EN is defined.
module uart_rx_csr #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        uart_rxd,
  input  logic        csr_rd,
  output logic [31:0] csr_rdata
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rxd_m, rxd_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             stop_wait;
  logic             byte_done;
  logic [7:0]       shift_p0;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, full, rd_hit, pop, push, oflow_set;
  logic             valid, oflow, ferr;
  logic [7:0]       data_p1;

  // Stage 0: input synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_wait <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: if (!rxd_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF_M1) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rxd_s ? IDLE : DATA;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DATA: if (cnt == DIV_M1) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        STOP: if (stop_wait) begin
          // Framing error: hold here until the line is idle again
          if (rxd_s) begin
            stop_wait <= 1'b0;
            state     <= IDLE;
          end
        end else if (cnt == DIV_M1) begin
          cnt <= '0;
          if (rxd_s) begin
            byte_done <= 1'b1;
            state     <= IDLE;
          end else begin
            stop_wait <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && cnt == DIV_M1) shift_p0 <= {rxd_s, shift_p0[7:1]};
  end

  // Stage 1: RxFIFO and head register
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_hit    = csr_rd && valid;
  assign pop       = !empty && (!valid || rd_hit);
  assign push      = byte_done && (!full || pop);
  assign oflow_set = byte_done && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shift_p0;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      valid   <= 1'b0;
      oflow   <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        valid   <= 1'b1;
        data_p1 <= mem[rptr[AW-1:0]];
      end else if (rd_hit) begin
        valid <= 1'b0;
      end
      if (oflow_set)   oflow <= 1'b1;
      else if (rd_hit) oflow <= 1'b0;
    end
  end

`ifdef UART_RX_FERR_EN
  logic ferr_set;
  assign ferr_set = (state == STOP) && !stop_wait && (cnt == DIV_M1) && !rxd_s;

  always_ff @(posedge clk) begin
    if (!srst_n)       ferr <= 1'b0;
    else if (ferr_set) ferr <= 1'b1;
    else if (csr_rd)   ferr <= 1'b0;
  end
`else
  assign ferr = 1'b0;
`endif

  assign csr_rdata = {valid, oflow, ferr, 21'b0, data_p1};

endmodule

// File: tb/tb_uart_rx_csr.sv
// Directed bench for uart_rx_csr: serial frames driven at the line rate, head bytes
// tracked in a scoreboard queue and checked on CSR reads.
module tb_uart_rx_csr;

  localparam int DIV = (25_000_000 + 115_200 / 2) / 115_200;

`ifdef UART_RX_FERR_EN
  localparam logic FERR_BIT = 1'b1;
`else
  localparam logic FERR_BIT = 1'b0;
`endif

  logic        clk;
  logic        srst_n;
  logic        uart_rxd;
  logic        csr_rd;
  logic [31:0] csr_rdata;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q[$];
  int          lat;
  logic [31:0] rv;

  uart_rx_csr dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .uart_rxd  (uart_rxd),
    .csr_rd    (csr_rd),
    .csr_rdata (csr_rdata)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one frame; optionally pulses csr_rd at stop-bit cycle rd_at and
  // reports the first stop-bit cycle at which valid is seen.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int rd_at,
                            output int lat_o, output logic [31:0] rd_val);
    logic [9:0] bits;
    bits   = {stop_b, b, 1'b0};
    lat_o  = -1;
    rd_val = '0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      for (int k = 1; k <= DIV; k++) begin
        @(negedge clk);
        if (i == 9) begin
          if (k == rd_at) begin
            csr_rd = 1'b1;
            rd_val = csr_rdata;
          end else begin
            csr_rd = 1'b0;
          end
          if (lat_o < 0 && csr_rdata[31]) lat_o = k;
        end
      end
    end
    csr_rd   = 1'b0;
    uart_rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic do_read(output logic [31:0] v);
    @(negedge clk);
    csr_rd = 1'b1;
    v      = csr_rdata;
    @(negedge clk);
    csr_rd = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs, input logic of);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h expected nothing (scoreboard empty)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, {1'b1, of, 1'b0, 21'b0, e});
    end
  endtask

  task automatic read_pop(input string tag, input logic of);
    logic [31:0] v;
    do_read(v);
    pop_chk(tag, v, of);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    srst_n      = 1'b0;
    uart_rxd    = 1'b1;
    csr_rd      = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset", csr_rdata, 32'h0);
    srst_n = 1'b1;

    // Short low glitch is rejected
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (40) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch", csr_rdata, 32'h0);

    // Single byte, latency and read-to-clear
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0, lat, rv);
    chk("a5_lat_window", {31'b0, (lat >= 111 && lat <= 113)}, 32'd1);
    chk("a5_word", csr_rdata, 32'h8000_00A5);
    read_pop("a5_read", 1'b0);
    chk("a5_after", csr_rdata, 32'h0000_00A5);

    // Overflow: six bytes into head + 4-entry FIFO
    for (int b = 1; b <= 6; b++) begin
      if (b <= 5) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 0, lat, rv);
    end
    chk("ovf_head", csr_rdata, 32'hC000_0001);
    for (int r = 0; r < 5; r++) read_pop("ovf_drain", (r == 0));
    chk("ovf_empty", csr_rdata, 32'h0000_0005);

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0, 0, lat, rv);
    chk("ferr_bad", csr_rdata, {1'b0, 1'b0, FERR_BIT, 21'b0, 8'h05});
    do_read(rv);
    chk("ferr_rd", rv, {1'b0, 1'b0, FERR_BIT, 21'b0, 8'h05});
    chk("ferr_clr", csr_rdata, 32'h0000_0005);
    exp_q.push_back(8'h3D);
    send_frame(8'h3D, 1'b1, 0, lat, rv);
    chk("ferr_good", csr_rdata, 32'h8000_003D);
    read_pop("ferr_good_rd", 1'b0);

    // Reset in the middle of data bit 4 of 0x5A
    @(negedge clk);
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        uart_rxd = bits[i];
        repeat (DIV) @(negedge clk);
      end
      uart_rxd = bits[5];
      repeat (100) @(negedge clk);
    end
    srst_n   = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    srst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_mid", csr_rdata, 32'h0);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 0, lat, rv);
    chk("rst_77", csr_rdata, 32'h8000_0077);
    read_pop("rst_77_rd", 1'b0);

    // Full FIFO with a head read landing on the push cycle
    for (int b = 0; b < 5; b++) begin
      exp_q.push_back(8'h10 + 8'(b));
      send_frame(8'h10 + 8'(b), 1'b1, 0, lat, rv);
    end
    chk("full_head", csr_rdata, 32'h8000_0010);
    exp_q.push_back(8'h15);
    send_frame(8'h15, 1'b1, 111, lat, rv);
    pop_chk("coinc_rd", rv, 1'b0);
    chk("coinc_head", csr_rdata, 32'h8000_0011);
    for (int r = 0; r < 5; r++) read_pop("coinc_drain", 1'b0);
    chk("coinc_empty", csr_rdata, 32'h0000_0015);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_csr.md
Name: uart_rx_csr

Overview:
- Hardware side of the UART_RX CSR (address 0x1).
- Deserialises the 115.2 kbps 8N1 serial input and buffers received bytes in a small RxFIFO.
- Presents the head byte to the CSR read mux in uart_rx_t layout, with valid and oflow flags.
- Implements the read-to-clear handoff with the CPU. Sits between the board RX pin and the CSR decoder's uart_rx select.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s. Fixed in HW; not SW-programmable.
- FIFO_DEPTH, 4, RxFIFO entries. Power of 2, ≥2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- srst_n  in  1  synchronous active-low reset.
- uart_rxd  in  1  asynchronous serial input; idle high.
- csr_rd  in  1  one-cycle strobe: CPU read of ADDR_UART_RX (decoder sel.uart_rx AND read).
- csr_rdata  out  32  {valid[31], oflow[30], 22'b0 [29:8], data[7:0]}. Registered; valid every cycle.

Behaviour:
- Reset (srst_n=0 at a clk edge):
  - csr_rdata=0; FIFO empty; receive FSM in IDLE; all counters 0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame discards the partial byte.
- Input sync: uart_rxd passes through a 2-FF synchroniser; rxd_s is the second stage. All decisions use rxd_s.
- Divisor: DIV = (CLK_HZ + BAUD/2)/BAUD (217 at defaults); HALF = DIV/2 (108). Baud counter is $clog2(DIV) bits and counts 0..DIV-1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rxd_s=0 -> START with counter cleared.
  - START: at count HALF-1, sample rxd_s. If 1 -> IDLE (glitch rejected). If 0 -> DATA with counter cleared and bit index 0.
  - DATA: every DIV cycles, sample into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after DIV cycles, sample. If 1 -> byte_done pulse for one cycle, then IDLE. If 0 (framing error) -> byte dropped, then wait in STOP until rxd_s=1, then IDLE.
- FIFO push: on byte_done.
  - FIFO full -> byte dropped and oflow set to 1.
  - oflow stays set until cleared by a read with valid=1.
- Head register (csr_rdata[31,7:0]):
  - When valid=0 and FIFO non-empty, pop into data and set valid=1 on the next edge (1-cycle latency).
  - A byte arriving into an empty FIFO with valid=0 therefore shows valid=1 two cycles after byte_done.
- Read handoff: csr_rd with valid=1 returns the current register value. At that edge:
  - oflow is cleared.
  - If the FIFO is non-empty, data is loaded from the FIFO head and valid stays 1.
  - Otherwise valid is cleared to 0; data is left unchanged.
- Reads with valid=0 change nothing, including oflow.
- Simultaneous events:
  - csr_rd clear and overflow drop in the same cycle -> oflow=1 (the new loss is reported).
  - Pop and push in the same cycle with the FIFO full -> the push succeeds (slot freed); no oflow.
- FIFO: circular buffer with $clog2(FIFO_DEPTH)+1-bit read/write pointers; full/empty are decided by MSB wrap. Pointers wrap modulo 2·FIFO_DEPTH.
- Writes to this address are ignored; the block has no write port.

Optional Feature:
- Macro: UART_RX_FERR_EN.
- Defined:
  - Adds sticky ferr at csr_rdata[29], set on a STOP-sample framing error.
  - ferr is cleared by any csr_rd, regardless of valid.
  - Simultaneous set and clear -> ferr=1.
- Undefined: bit 29 is constant 0; framing errors silently drop the byte.

Test Plan:
- Reset, then send 0xA5 at 115_200 -> csr_rdata becomes 0x8000_00A5 within 2 cycles of the stop-bit sample. Read -> next cycle valid=0, data still 0xA5.
- Low pulse on uart_rxd of 40 cycles (< HALF) -> FSM returns to IDLE; no byte; csr_rdata stays 0.
- Send 0x01..0x06 with no reads (depth 4) -> head 0x01 plus FIFO 0x02..0x05; 0x06 dropped; csr_rdata=0xC000_0001. Five reads return 0x01..0x05, the first with oflow=1, the rest with oflow=0; sixth read shows valid=0.
- Framing error: send 0x3C with stop bit 0 -> no valid. Line returns high, then send 0x3D -> csr_rdata=0x8000_003D. With UART_RX_FERR_EN: after the bad frame bit 29=1; after one read bit 29=0.
- Assert srst_n=0 at DATA bit 4 of 0x5A, release, then send 0x77 -> only 0x77 appears; oflow=0.
- Fill the FIFO; byte_done coincides with a csr_rd of the head -> new byte stored, oflow=0. Drain yields all bytes in order.
